// File: rtl/sfifo_rd_bridge_if.sv
// Handshake bundle between sfifo_rd_bridge, its FIFO read port and the downstream stream.
// master: the bridge side; slave: the FIFO/consumer environment side.
interface sfifo_rd_bridge_if #(
   parameter int unsigned FIFO_WIDTH = 8
);
   logic                  fifo_empty;
   logic [FIFO_WIDTH-1:0] fifo_rdata;
   logic                  fifo_ren;
   logic                  m_valid;
   logic [FIFO_WIDTH-1:0] m_data;
   logic                  m_ready;

   modport master (
      input  fifo_empty,
      input  fifo_rdata,
      input  m_ready,
      output fifo_ren,
      output m_valid,
      output m_data
   );

   modport slave (
      output fifo_empty,
      output fifo_rdata,
      output m_ready,
      input  fifo_ren,
      input  m_valid,
      input  m_data
   );
endinterface

// File: rtl/sfifo_rd_bridge.sv
// Read-side bridge: sfifo read port to valid/ready stream with credit-based skid buffer and flush.
// Define SFIFO_RD_CNT_EN to add the 32-bit delivered-word counter output rd_word_cnt.
module sfifo_rd_bridge #(
   parameter int unsigned FIFO_WIDTH = 8,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned BUF_DEEP   = RD_LATENCY + 1
) (
   input  logic              clk_sys,
   input  logic              reset,
   sfifo_rd_bridge_if.master bus_io,
   input  logic              flush,
   output logic              flush_done
`ifdef SFIFO_RD_CNT_EN
   ,
   output logic [31:0]       rd_word_cnt
`endif
);

   localparam int unsigned PtrW = (BUF_DEEP > 2) ? 2 : 1;
   localparam int unsigned CntW = 3;

   typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

   state_e                state_q, state_d;
   logic [RD_LATENCY-1:0] iss_q, iss_d;
   logic [CntW-1:0]       inflight_q, inflight_d;
   logic [CntW-1:0]       buf_cnt_q, buf_cnt_d;
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [FIFO_WIDTH-1:0] mem_q [BUF_DEEP];

   logic       valid, pop, ret, push, ren;
   logic [3:0] credit;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(BUF_DEEP - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign valid  = (buf_cnt_q != '0);
   assign pop    = valid && bus_io.m_ready;
   assign ret    = iss_q[RD_LATENCY-1];
   assign push   = ret && (state_q == StRun) && !flush;
   // Slots already promised (in flight + buffered) minus the one leaving this cycle.
   assign credit = 4'(inflight_q) + 4'(buf_cnt_q) - 4'(pop);
   assign ren    = !reset && (state_q == StRun) && !flush && !bus_io.fifo_empty &&
                   (credit < 4'(BUF_DEEP));

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // With nothing in flight there is nothing to drain, so skip straight to DONE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (flush) state_d = (inflight_q == '0) ? StDone : StFlush;
         StFlush: if (inflight_q == '0) state_d = StDone;
         StDone:  state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      bus_io.fifo_ren = ren;
      bus_io.m_valid  = valid;
      bus_io.m_data   = mem_q[rd_ptr_q];
      flush_done      = (state_q == StDone);
   end

   always_comb begin
      iss_d[0] = ren;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
         iss_d[i] = iss_q[i-1];
      end
      inflight_d = inflight_q + CntW'(ren) - CntW'(ret);
      buf_cnt_d  = buf_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if ((state_q != StRun) || flush) begin
         buf_cnt_d = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
         buf_cnt_d = buf_cnt_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         iss_q      <= '0;
         inflight_q <= '0;
         buf_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int unsigned i = 0; i < BUF_DEEP; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         iss_q      <= iss_d;
         inflight_q <= inflight_d;
         buf_cnt_q  <= buf_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         if (push) mem_q[wr_ptr_q] <= bus_io.fifo_rdata;
      end
   end

`ifdef SFIFO_RD_CNT_EN
   logic [31:0] word_cnt_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         word_cnt_q <= '0;
      end else if (pop) begin
         word_cnt_q <= word_cnt_q + 32'd1;
      end
   end

   assign rd_word_cnt = word_cnt_q;
`endif

endmodule
